regfile_access_ctrl: RTL

Multi-cycle sequencer that drives the register file's port interface (rs1/rs2 read addresses, rd/wd3/regwrite write port) on behalf of the control unit. It accepts one decoded instruction's register fields, reads both operands, and holds them for the ALU. It then waits for the execute result and performs the writeback in a single-cycle regwrite pulse. It sits between the multi-cycle control FSM and reg_file.

---
 rtl/regfile_access_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Sequences one instruction through the register file: operand read, wait for execute, writeback.
// Latency: accept->ops_valid 2 edges; res_valid->done 2 edges with write, 1 edge without.
// Backpressure: op_ready only in IDLE, no queueing; waits indefinitely in EXEC for res_valid.
module regfile_access_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int R0_PROTECT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [ADDR_W-1:0] op_rs1,
    input  logic [ADDR_W-1:0] op_rs2,
    input  logic [ADDR_W-1:0] op_rd,
    input  logic              op_wb,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic              ops_valid,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              done,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              rf_regwrite,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_wd3;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic              r_wb;
    logic              w_do_write;

    assign w_do_write = r_wb && !((R0_PROTECT != 0) && (r_rd == '0));

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (op_valid) w_next = S_READ;
                S_READ:  w_next = S_EXEC;
                S_EXEC:  if (res_valid) w_next = w_do_write ? S_WRITE : S_DONE;
                S_WRITE: w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath captures are suppressed under flush so an aborted result never lands in rf_wd3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_rd  <= '0;
            r_wb  <= 1'b0;
            r_opa <= '0;
            r_opb <= '0;
            r_wd3 <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_rs1 <= op_rs1;
                        r_rs2 <= op_rs2;
                        r_rd  <= op_rd;
                        r_wb  <= op_wb;
                    end
                end
                S_READ: begin
                    r_opa <= rf_rd1;
                    r_opb <= rf_rd2;
                end
                S_EXEC: begin
                    if (res_valid) r_wd3 <= res_data;
                end
                default: ;
            endcase
        end
    end

    assign op_ready    = (r_state == S_IDLE);
    assign ops_valid   = (r_state == S_EXEC);
    assign rf_regwrite = (r_state == S_WRITE);
    assign done        = (r_state == S_DONE);
    assign opa         = r_opa;
    assign opb         = r_opb;
    assign rf_rs1      = r_rs1;
    assign rf_rs2      = r_rs2;
    assign rf_rd       = r_rd;
    assign rf_wd3      = r_wd3;

endmodule
